// File: rtl/mdu_pkg.sv
//------------------------------------------------------------------------------
// mdu_pkg : shared MDU opcodes, default latencies and result helper
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MTHI  = 4'd5,
    MDU_MTLO  = 4'd6,
    MDU_MFHI  = 4'd7,
    MDU_MFLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Returns {HI, LO}. Signed division works on magnitudes, so INT_MIN / -1
  // wraps to {0, 0x80000000} without a special case.
  function automatic logic [63:0] mdu_compute(input logic [3:0]  op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
    logic [63:0] res;
    logic [31:0] ua, ub, q, r;
    res = 64'd0;
    ua  = a;
    ub  = b;
    if (op == MDU_DIV) begin
      ua = a[31] ? (32'd0 - a) : a;
      ub = b[31] ? (32'd0 - b) : b;
    end
    if (ub != 32'd0) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      q = 32'd0;
      r = 32'd0;
    end
    case (op)
      MDU_MULT:  res = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
      MDU_MULTU: res = {32'd0, a} * {32'd0, b};
      MDU_DIV:   res = {(a[31] ? (32'd0 - r) : r),
                        ((a[31] ^ b[31]) ? (32'd0 - q) : q)};
      MDU_DIVU:  res = {r, q};
      default:   res = 64'd0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_if.sv
//------------------------------------------------------------------------------
// mdu_if : operand/opcode/handshake bundle between controller and MDU
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mdu_if;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  MDUOP;
  logic        Start;
  logic        Busy;
  logic [31:0] MDUOut;

  modport master (
    output SrcA, SrcB, MDUOP, Start,
    input  Busy, MDUOut
  );

  modport slave (
    input  SrcA, SrcB, MDUOP, Start,
    output Busy, MDUOut
  );
endinterface

`default_nettype wire

// File: rtl/mdu.sv
//------------------------------------------------------------------------------
// mdu : multi-cycle multiply/divide unit with HI/LO registers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [63:0]      res_q;
  logic             wr_q;

  logic             is_mul_d;
  logic             is_div_d;
  logic             launch_d;
  logic             wr_d;
  logic [CNT_W-1:0] cnt_d;
  logic [63:0]      res_d;
  logic [31:0]      out_d;

  always_comb begin
    is_mul_d = (bus.MDUOP == MDU_MULT) || (bus.MDUOP == MDU_MULTU);
    is_div_d = (bus.MDUOP == MDU_DIV)  || (bus.MDUOP == MDU_DIVU);
    launch_d = bus.Start && (is_mul_d || is_div_d) && (state_q == ST_IDLE);
    // A zero divisor still occupies the unit but must not touch HI/LO.
    wr_d     = !(is_div_d && (bus.SrcB == 32'd0));
    cnt_d    = is_mul_d ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    res_d    = mdu_compute(bus.MDUOP, bus.SrcA, bus.SrcB);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      res_q   <= 64'd0;
      wr_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch_d) begin
            res_q   <= res_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else if (bus.MDUOP == MDU_MTHI) begin
            hi_q <= bus.SrcA;
          end else if (bus.MDUOP == MDU_MTLO) begin
            lo_q <= bus.SrcA;
          end
        end
        ST_RUN: begin
          if (cnt_q <= CNT_W'(1)) begin
            if (wr_q) begin
              hi_q <= res_q[63:32];
              lo_q <= res_q[31:0];
            end
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    out_d = 32'd0;
    if (bus.MDUOP == MDU_MFHI) begin
      out_d = hi_q;
    end else if (bus.MDUOP == MDU_MFLO) begin
      out_d = lo_q;
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.MDUOut = out_d;

endmodule

`default_nettype wire
